// File: rtl/conv_pkg.sv
// Shared definitions for the convolution result readout path: bus widths,
// readout FSM state type and the word-index to byte-address helper.
package conv_pkg;

  localparam int DATA_W     = 32;
  localparam int ADDR_W     = 32;
  localparam int ADDR_SHIFT = 2;   // word index -> byte address (4-byte words)
  localparam int IDX_W      = 17;  // holds 0..65536 so a 65536-word frame can count past its last index

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // Byte address of result word idx relative to the frame base.
  function automatic logic [ADDR_W-1:0] word_byte_addr(input logic [ADDR_W-1:0] base,
                                                       input logic [IDX_W-1:0]  idx);
    word_byte_addr = base + (ADDR_W'(idx) << ADDR_SHIFT);
  endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO that catches BRAM read data one cycle after the read and
// presents it to the stream side. Push and pop in the same cycle are allowed,
// including push while full as long as a pop frees the slot in that cycle.
module rd_skid_fifo
  import conv_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign data_o  = mem_q[rd_ptr_q];

  // Qualify push/pop against occupancy and derive next pointers and count.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q ^ do_push;
    rd_ptr_d = rd_ptr_q ^ do_pop;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;  // idle, or push+pop leaves occupancy unchanged
    endcase
  end

  // Control state: pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage: data needs no reset, the empty flag masks stale entries.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/conv_result_reader.sv
// Reads one frame of convolution results out of the result BRAM and streams
// them in address order. Reads are throttled so that words in flight plus
// words buffered never exceed the two-entry FIFO, which lets the stream run
// at one beat per cycle while surviving arbitrary backpressure.
module conv_result_reader
  import conv_pkg::*;
#(
  parameter int                IMG_WIDTH  = 18,
  parameter int                IMG_HEIGHT = 18,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h0,
  parameter int                NUM_WORDS  = (IMG_WIDTH-2)*(IMG_HEIGHT-2)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] m_tdata,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic              m_tlast
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]  beat_q, beat_d;
  logic              inflight_q;

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;
  logic              issue;
  logic [1:0]        buffered;
  logic [2:0]        level;

  // Read data arrives the cycle after bram_en and is pushed straight in.
  rd_skid_fifo #(
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .data_i  (bram_dout),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop       = !fifo_empty && m_tready;
  assign m_tvalid  = !fifo_empty;
  assign m_tdata   = fifo_empty ? '0 : fifo_head;
  assign m_tlast   = !fifo_empty && (beat_q == LAST_IDX);
  assign busy      = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done      = (state_q == ST_FINISH);
  assign bram_en   = issue;
  assign bram_addr = issue ? word_byte_addr(BASE_ADDR, rd_idx_q) : '0;

  // Issue a read only if the word it returns is guaranteed a FIFO slot; a pop
  // in this cycle frees one, which is what sustains one beat per cycle.
  always_comb begin
    buffered = fifo_full ? 2'd2 : (fifo_empty ? 2'd0 : 2'd1);
    level    = 3'(buffered) + 3'(inflight_q) - 3'(pop);
    issue    = (state_q == ST_READ) && (level < 3'd2);
  end

  // Readout FSM and read/beat index bookkeeping.
  always_comb begin
    state_d  = state_q;
    rd_idx_d = rd_idx_q;
    beat_d   = pop ? beat_q + 1'b1 : beat_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d  = ST_READ;
          rd_idx_d = '0;
          beat_d   = '0;
        end
      end
      ST_READ: begin
        if (issue) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == LAST_IDX) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pop && (beat_q == LAST_IDX)) begin
          state_d = ST_FINISH;
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset aborts any frame in progress, including a read
  // still in flight, so nothing is emitted until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rd_idx_q   <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rd_idx_q   <= rd_idx_d;
      beat_q     <= beat_d;
      inflight_q <= issue;
    end
  end

endmodule

// File: tb/tb_conv_result_reader.sv
// Bench for conv_result_reader: a default 18x18 instance driven through
// several frames with varying backpressure, and a single-word instance at a
// non-zero base address.
module tb_conv_result_reader;

  localparam int N = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        a_start, a_busy, a_done, a_bram_en, a_tvalid, a_tready, a_tlast;
  logic [31:0] a_bram_addr, a_bram_dout, a_tdata;
  logic        b_start, b_busy, b_done, b_bram_en, b_tvalid, b_tready, b_tlast;
  logic [31:0] b_bram_addr, b_bram_dout, b_tdata;

  conv_result_reader #(
    .IMG_WIDTH (18), .IMG_HEIGHT (18), .BASE_ADDR (32'h0)
  ) dut_a (
    .clk (clk), .rst_n (rst_n), .start (a_start), .busy (a_busy), .done (a_done),
    .bram_en (a_bram_en), .bram_addr (a_bram_addr), .bram_dout (a_bram_dout),
    .m_tdata (a_tdata), .m_tvalid (a_tvalid), .m_tready (a_tready), .m_tlast (a_tlast)
  );

  conv_result_reader #(
    .IMG_WIDTH (18), .IMG_HEIGHT (18), .BASE_ADDR (32'h100), .NUM_WORDS (1)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .start (b_start), .busy (b_busy), .done (b_done),
    .bram_en (b_bram_en), .bram_addr (b_bram_addr), .bram_dout (b_bram_dout),
    .m_tdata (b_tdata), .m_tvalid (b_tvalid), .m_tready (b_tready), .m_tlast (b_tlast)
  );

  // Result memory contents for dut_a; word i lives at byte address 4*i.
  logic [31:0] mem_a [N];

  // BRAM models: one-cycle read latency, junk on cycles without a read.
  always @(posedge clk) begin
    if (a_bram_en) a_bram_dout <= (a_bram_addr[31:2] < N) ? mem_a[a_bram_addr[9:2]] : 32'hDEAD_BEEF;
    else           a_bram_dout <= $urandom;
    if (b_bram_en) b_bram_dout <= (b_bram_addr == 32'h100) ? 32'hCAFE_0000 : 32'hBAD0_BAD0;
    else           b_bram_dout <= $urandom;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at time %0t", name, got, exp, $time);
  endtask

  // Downstream ready: 0 = always high, 1 = held low, 2 = random 50%.
  int ready_mode = 0;
  initial begin
    a_tready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (ready_mode)
        0:       a_tready = 1'b1;
        1:       a_tready = 1'b0;
        default: a_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Reference model for dut_a: the frame is the list mem_a[0..N-1]; reads
  // must walk addresses 0,4,8,.. once each, beats must replay the list in
  // order, and reads issued minus beats taken never exceeds two.
  bit          act, done_now, prev_stall, prev_last, got_first, xfer, next_done;
  logic [31:0] prev_data, last_data;
  int          issued, beats, done_count, start_cyc, first_valid_cyc, done_cyc;

  initial begin
    act = 0; done_now = 0; prev_stall = 0; prev_last = 0; got_first = 0;
    prev_data = '0; last_data = '0;
    issued = 0; beats = 0; done_count = 0; start_cyc = 0; first_valid_cyc = 0; done_cyc = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_busy",  32'(a_busy),   0);
        check("rst_done",  32'(a_done),   0);
        check("rst_en",    32'(a_bram_en), 0);
        check("rst_addr",  a_bram_addr,   0);
        check("rst_valid", 32'(a_tvalid), 0);
        check("rst_last",  32'(a_tlast),  0);
        check("rst_data",  a_tdata,       0);
        check("rst_b_valid", 32'(b_tvalid), 0);
        act = 0; done_now = 0; prev_stall = 0; issued = 0; beats = 0;
      end else begin
        check("busy", 32'(a_busy), 32'(act));
        check("done", 32'(a_done), 32'(done_now));
        if (done_now) begin
          done_count++;
          done_cyc = cyc;
        end
        if (!act) check("valid_outside_frame", 32'(a_tvalid), 0);
        if (a_bram_en) begin
          check("read_in_frame", 32'(act), 1);
          check("read_count_limit", 32'(issued < N), 1);
          check("bram_addr", a_bram_addr, 32'(issued * 4));
          issued++;
        end
        if (prev_stall) begin
          check("stall_valid", 32'(a_tvalid), 1);
          check("stall_data",  a_tdata, prev_data);
          check("stall_last",  32'(a_tlast), 32'(prev_last));
        end
        if (a_tvalid) begin
          check("tlast", 32'(a_tlast), 32'(beats == N - 1));
          if (!got_first) begin
            first_valid_cyc = cyc;
            got_first = 1;
          end
        end else begin
          check("tlast_without_valid", 32'(a_tlast), 0);
        end
        xfer = a_tvalid && a_tready;
        if (xfer) begin
          check("beat_in_range", 32'(beats < N), 1);
          if (beats < N) check("tdata", a_tdata, mem_a[beats]);
          if (a_tlast) last_data = a_tdata;
          beats++;
        end
        check("outstanding_le_2", 32'((issued - beats) <= 2), 1);
        prev_stall = a_tvalid && !a_tready;
        prev_data  = a_tdata;
        prev_last  = a_tlast;
        next_done  = act && xfer && (beats == N);
        if (act) begin
          act = !next_done;
        end else if (a_start && !done_now) begin
          act = 1; issued = 0; beats = 0; start_cyc = cyc; got_first = 0;
        end
        done_now = next_done;
      end
    end
  end

  task automatic pulse_a_start();
    @(posedge clk); #1 a_start = 1'b1;
    @(posedge clk); #1 a_start = 1'b0;
  endtask

  task automatic wait_frame(input int snap, input string tag);
    for (int k = 0; k < 4000 && done_count == snap; k++) @(posedge clk);
    check({tag, "_completed"}, 32'(done_count != snap), 1);
    repeat (4) @(posedge clk);
    check({tag, "_one_done"}, 32'(done_count - snap), 1);
  endtask

  task automatic wait_beats(input int target, input string tag);
    for (int k = 0; k < 4000 && beats < target; k++) @(posedge clk);
    check({tag, "_reached"}, 32'(beats >= target), 1);
  endtask

  int snap, en_late, valid_low, idle_valid;

  initial begin
    a_start = 1'b0; b_start = 1'b0; b_tready = 1'b1;
    for (int i = 0; i < N; i++) mem_a[i] = 32'(i);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Frame 1: ready held high, data = index.
    snap = done_count;
    pulse_a_start();
    wait_frame(snap, "f1");
    check("f1_start_to_done", 32'(done_cyc - start_cyc), 259);
    check("f1_first_valid",   32'(first_valid_cyc - start_cyc), 3);  // two cycles after busy rises
    check("f1_beats",         32'(beats), 256);
    check("f1_reads",         32'(issued), 256);
    check("f1_last_data",     last_data, 32'd255);

    // Frame 2: random 50% backpressure.
    ready_mode = 2;
    snap = done_count;
    pulse_a_start();
    wait_frame(snap, "f2");
    check("f2_beats",     32'(beats), 256);
    check("f2_last_data", last_data, 32'd255);
    ready_mode = 0;

    // Frame 3: random contents, 20-cycle stall mid-frame.
    for (int i = 0; i < N; i++) mem_a[i] = $urandom;
    snap = done_count;
    pulse_a_start();
    wait_beats(80, "f3_pre_stall");
    @(posedge clk); #1 ready_mode = 1;
    en_late = 0; valid_low = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 3 && a_bram_en) en_late++;
      if (i >= 1 && !a_tvalid) valid_low++;
    end
    check("f3_stall_reads", 32'(en_late), 0);
    check("f3_stall_valid_low", 32'(valid_low), 0);
    @(posedge clk); #1 ready_mode = 0;
    wait_frame(snap, "f3");
    check("f3_beats",     32'(beats), 256);
    check("f3_last_data", last_data, mem_a[N-1]);

    // Frame 4: second start at beat 100 must be ignored.
    for (int i = 0; i < N; i++) mem_a[i] = $urandom;
    ready_mode = 2;
    snap = done_count;
    pulse_a_start();
    wait_beats(100, "f4_beat100");
    pulse_a_start();
    wait_frame(snap, "f4");
    check("f4_beats", 32'(beats), 256);
    check("f4_reads", 32'(issued), 256);
    ready_mode = 0;

    // Frame 5: reset at beat 50, then a clean frame.
    for (int i = 0; i < N; i++) mem_a[i] = 32'(i);
    ready_mode = 2;
    pulse_a_start();
    wait_beats(50, "f5_beat50");
    @(posedge clk); #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    ready_mode = 0;
    idle_valid = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_tvalid || a_busy || a_bram_en) idle_valid++;
    end
    check("f5_quiet_after_reset", 32'(idle_valid), 0);
    snap = done_count;
    pulse_a_start();
    wait_frame(snap, "f5");
    check("f5_start_to_done", 32'(done_cyc - start_cyc), 259);
    check("f5_beats",         32'(beats), 256);
    check("f5_last_data",     last_data, 32'd255);

    // Single-word instance at base 0x100.
    @(posedge clk); #1 b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    @(negedge clk);
    check("b_c1_busy", 32'(b_busy), 1);
    check("b_c1_en",   32'(b_bram_en), 1);
    check("b_c1_addr", b_bram_addr, 32'h100);
    @(negedge clk);
    check("b_c2_en",    32'(b_bram_en), 0);
    check("b_c2_valid", 32'(b_tvalid), 0);
    @(negedge clk);
    check("b_c3_valid", 32'(b_tvalid), 1);
    check("b_c3_last",  32'(b_tlast), 1);
    check("b_c3_data",  b_tdata, 32'hCAFE_0000);
    check("b_c3_en",    32'(b_bram_en), 0);
    check("b_c3_done",  32'(b_done), 0);
    @(negedge clk);
    check("b_c4_done",  32'(b_done), 1);
    check("b_c4_busy",  32'(b_busy), 0);
    check("b_c4_valid", 32'(b_tvalid), 0);
    @(negedge clk);
    check("b_c5_done",  32'(b_done), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, passed %0d of %0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
